branch_stack: RTL and testbench

- Checkpoint store for in-flight branches in the R10K-style OoO core. Sits between dispatch, branch resolution and the free list.
- On each dispatched branch it captures a free-list snapshot and hands out a one-hot branch mask bit.
- Retiring physical registers are merged into every live snapshot each cycle.
- On a mispredict it drives free_list_restore/restore_flag to the free list and reports which branch masks to squash.

---
 rtl/branch_stack.sv | 112 +++++++++++
 tb/tb_branch_stack.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_stack.sv
// Branch checkpoint store: per-branch free-list snapshots, one-hot branch masks,
// and mispredict restore/squash generation for the out-of-order core.
module branch_stack #(
  parameter int N               = 3,
  parameter int PHYS_REG_SZ     = 64,
  parameter int NUM_CHECKPOINTS = 4
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          branch_dispatch_valid,
  input  logic [PHYS_REG_SZ-1:0]                        dispatch_free_list,
  input  logic [N-1:0][$clog2(PHYS_REG_SZ)-1:0]         phys_reg_retiring,
  input  logic [$clog2(N+1)-1:0]                        num_retiring_valid,
  input  logic                                          resolve_valid,
  input  logic [NUM_CHECKPOINTS-1:0]                    resolve_mask,
  input  logic                                          resolve_mispredict,
  output logic [NUM_CHECKPOINTS-1:0]                    allocated_mask,
  output logic [NUM_CHECKPOINTS-1:0]                    current_mask,
  output logic                                          stack_full,
  output logic [PHYS_REG_SZ-1:0]                        free_list_restore,
  output logic                                          restore_flag,
  output logic [NUM_CHECKPOINTS-1:0]                    squash_mask
);
  localparam int NC    = NUM_CHECKPOINTS;
  localparam int PR    = PHYS_REG_SZ;
  localparam int CNT_W = $clog2(N+1);

  logic [NC-1:0] valid_r;
  logic [PR-1:0] snapshot_r [NC];
  logic [NC-1:0] older_r    [NC];

  logic [PR-1:0] retire_bits_s;
  logic          onehot_s;
  logic          target_hit_s;
  logic          mispredict_s;
  logic          correct_s;
  logic          alloc_en_s;
  logic [NC-1:0] alloc_onehot_s;
  logic [NC-1:0] alloc_sel_s;
  logic [NC-1:0] squash_s;
  logic [NC-1:0] freed_s;
  logic [PR-1:0] restore_s;

  // Retirement vector from the valid low-index retire slots.
  always_comb begin
    retire_bits_s = {PR{1'b0}};
    for (int j = 0; j < N; j++) begin
      retire_bits_s = retire_bits_s |
        ((CNT_W'(j) < num_retiring_valid) ? ({{(PR-1){1'b0}}, 1'b1} << phys_reg_retiring[j])
                                          : {PR{1'b0}});
    end
  end

  // Resolve decode, squash set, restore snapshot and allocation choice.
  always_comb begin
    onehot_s     = (resolve_mask != {NC{1'b0}}) &&
                   ((resolve_mask & (resolve_mask - {{(NC-1){1'b0}}, 1'b1})) == {NC{1'b0}});
    target_hit_s = resolve_valid && onehot_s && ((resolve_mask & valid_r) != {NC{1'b0}});
    mispredict_s = target_hit_s && resolve_mispredict;
    correct_s    = target_hit_s && !resolve_mispredict;

    squash_s  = {NC{1'b0}};
    restore_s = {PR{1'b0}};
    for (int i = 0; i < NC; i++) begin
      // An entry is younger than the target if the target was live when it was allocated.
      squash_s[i] = resolve_mask[i] | (valid_r[i] & ((older_r[i] & resolve_mask) != {NC{1'b0}}));
      restore_s   = restore_s | (resolve_mask[i] ? snapshot_r[i] : {PR{1'b0}});
    end

    freed_s = mispredict_s ? squash_s : (correct_s ? resolve_mask : {NC{1'b0}});

    alloc_en_s     = branch_dispatch_valid && !(&valid_r) && !(resolve_valid && resolve_mispredict);
    alloc_onehot_s = ~valid_r & (valid_r + {{(NC-1){1'b0}}, 1'b1});
    alloc_sel_s    = alloc_en_s ? alloc_onehot_s : {NC{1'b0}};
  end

  // Output drive; restore/squash are only non-zero on a live mispredict.
  always_comb begin
    allocated_mask    = alloc_sel_s;
    current_mask      = valid_r;
    stack_full        = &valid_r;
    restore_flag      = mispredict_s;
    squash_mask       = mispredict_s ? squash_s : {NC{1'b0}};
    free_list_restore = mispredict_s ? restore_s : {PR{1'b0}};
  end

  // Checkpoint state update: free/squash, allocate, merge retirements.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= {NC{1'b0}};
      for (int i = 0; i < NC; i++) begin
        snapshot_r[i] <= {PR{1'b0}};
        older_r[i]    <= {NC{1'b0}};
      end
    end else begin
      for (int i = 0; i < NC; i++) begin
        older_r[i] <= older_r[i] & ~freed_s;
        if (freed_s[i]) begin
          valid_r[i] <= 1'b0;
        end else if (alloc_sel_s[i]) begin
          valid_r[i]    <= 1'b1;
          snapshot_r[i] <= dispatch_free_list | retire_bits_s;
          older_r[i]    <= valid_r & ~freed_s;
        end else if (valid_r[i]) begin
          snapshot_r[i] <= snapshot_r[i] | retire_bits_s;
        end else begin
          snapshot_r[i] <= snapshot_r[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_stack.sv
// Directed self-checking bench for branch_stack: allocation, retirement merge,
// squash/restore, correct resolve, mispredict priority and reset.
module tb_branch_stack;
  logic              clock = 1'b0;
  logic              reset;
  logic              branch_dispatch_valid;
  logic [63:0]       dispatch_free_list;
  logic [2:0][5:0]   phys_reg_retiring;
  logic [1:0]        num_retiring_valid;
  logic              resolve_valid;
  logic [3:0]        resolve_mask;
  logic              resolve_mispredict;
  logic [3:0]        allocated_mask;
  logic [3:0]        current_mask;
  logic              stack_full;
  logic [63:0]       free_list_restore;
  logic              restore_flag;
  logic [3:0]        squash_mask;

  int errors = 0;
  int checks = 0;

  branch_stack #(.N(3), .PHYS_REG_SZ(64), .NUM_CHECKPOINTS(4)) dut (
    .clock(clock), .reset(reset),
    .branch_dispatch_valid(branch_dispatch_valid), .dispatch_free_list(dispatch_free_list),
    .phys_reg_retiring(phys_reg_retiring), .num_retiring_valid(num_retiring_valid),
    .resolve_valid(resolve_valid), .resolve_mask(resolve_mask),
    .resolve_mispredict(resolve_mispredict),
    .allocated_mask(allocated_mask), .current_mask(current_mask), .stack_full(stack_full),
    .free_list_restore(free_list_restore), .restore_flag(restore_flag),
    .squash_mask(squash_mask)
  );

  always #5 clock = ~clock;

  task automatic idle();
    branch_dispatch_valid = 1'b0;
    dispatch_free_list    = 64'h0;
    phys_reg_retiring     = '0;
    num_retiring_valid    = 2'd0;
    resolve_valid         = 1'b0;
    resolve_mask          = 4'b0000;
    resolve_mispredict    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic dispatch(input logic [63:0] fl);
    branch_dispatch_valid = 1'b1;
    dispatch_free_list    = fl;
    tick();
    idle();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({allocated_mask, current_mask, stack_full, restore_flag, squash_mask} !== 14'd0 ||
        free_list_restore !== 64'h0) begin
      errors++;
      $display("FAIL reset_outputs: alloc=%b cur=%b full=%b rf=%b sq=%b flr=%h required all zero",
               allocated_mask, current_mask, stack_full, restore_flag, squash_mask, free_list_restore);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      branch_dispatch_valid = 1'b1;
      dispatch_free_list    = 64'hF0 << (4 * k);
      #1;
      checks++;
      if (allocated_mask !== (4'b0001 << k)) begin
        errors++;
        $display("FAIL fill_alloc%0d: got %b required %b", k, allocated_mask, 4'b0001 << k);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (stack_full !== 1'b1 || current_mask !== 4'b1111) begin
      errors++;
      $display("FAIL fill_full: full=%b cur=%b required 1 1111", stack_full, current_mask);
    end
    branch_dispatch_valid = 1'b1;
    #1;
    checks++;
    if (allocated_mask !== 4'b0000) begin
      errors++;
      $display("FAIL alloc_when_full: got %b required 0000", allocated_mask);
    end
    tick();
    idle();
  endtask

  task automatic test_retire();
    do_reset();
    dispatch(64'hF0);
    dispatch(64'hF00);
    phys_reg_retiring[0] = 6'd5;
    phys_reg_retiring[1] = 6'd9;
    phys_reg_retiring[2] = 6'd12;
    num_retiring_valid   = 2'd2;
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mask = 4'b0010; resolve_mispredict = 1'b1;
    #1;
    checks++;
    if (restore_flag !== 1'b1 || free_list_restore !== 64'hF20 || squash_mask !== 4'b0010) begin
      errors++;
      $display("FAIL retire_restore1: rf=%b flr=%h sq=%b required 1 f20 0010",
               restore_flag, free_list_restore, squash_mask);
    end
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b1;
    #1;
    checks++;
    if (free_list_restore !== 64'h2F0 || squash_mask !== 4'b0001) begin
      errors++;
      $display("FAIL retire_restore0: flr=%h sq=%b required 2f0 0001", free_list_restore, squash_mask);
    end
    tick();
    idle();
    #1;
    checks++;
    if (current_mask !== 4'b0000) begin
      errors++;
      $display("FAIL retire_empty: cur=%b required 0000", current_mask);
    end
  endtask

  task automatic test_squash();
    do_reset();
    dispatch(64'h1);
    dispatch(64'h2);
    dispatch(64'h4);
    resolve_valid = 1'b1; resolve_mask = 4'b0010; resolve_mispredict = 1'b1;
    #1;
    checks++;
    if (restore_flag !== 1'b1 || squash_mask !== 4'b0110 || free_list_restore !== 64'h2) begin
      errors++;
      $display("FAIL squash_same_cycle: rf=%b sq=%b flr=%h required 1 0110 2",
               restore_flag, squash_mask, free_list_restore);
    end
    tick();
    idle();
    #1;
    checks++;
    if (current_mask !== 4'b0001 || stack_full !== 1'b0) begin
      errors++;
      $display("FAIL squash_after: cur=%b full=%b required 0001 0", current_mask, stack_full);
    end
  endtask

  task automatic test_correct_resolve();
    do_reset();
    dispatch(64'h10);
    dispatch(64'h20);
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b0;
    branch_dispatch_valid = 1'b1;
    #1;
    checks++;
    if (restore_flag !== 1'b0 || squash_mask !== 4'b0000 || allocated_mask !== 4'b0100) begin
      errors++;
      $display("FAIL correct_same_cycle: rf=%b sq=%b alloc=%b required 0 0000 0100",
               restore_flag, squash_mask, allocated_mask);
    end
    tick();
    idle();
    #1;
    checks++;
    if (current_mask !== 4'b0110) begin
      errors++;
      $display("FAIL correct_after: cur=%b required 0110", current_mask);
    end
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'h40;
    #1;
    checks++;
    if (allocated_mask !== 4'b0001) begin
      errors++;
      $display("FAIL reuse_alloc: got %b required 0001", allocated_mask);
    end
    tick();
    idle();
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b1;
    #1;
    checks++;
    if (squash_mask !== 4'b0001 || free_list_restore !== 64'h40) begin
      errors++;
      $display("FAIL reuse_squash: sq=%b flr=%h required 0001 40", squash_mask, free_list_restore);
    end
    tick();
    idle();
    #1;
    checks++;
    if (current_mask !== 4'b0110) begin
      errors++;
      $display("FAIL reuse_after: cur=%b required 0110", current_mask);
    end
  endtask

  task automatic test_mispredict_vs_alloc();
    do_reset();
    dispatch(64'hA);
    dispatch(64'hB);
    resolve_valid = 1'b1; resolve_mask = 4'b0001; resolve_mispredict = 1'b1;
    branch_dispatch_valid = 1'b1; dispatch_free_list = 64'hC;
    #1;
    checks++;
    if (allocated_mask !== 4'b0000 || squash_mask !== 4'b0011 || free_list_restore !== 64'hA) begin
      errors++;
      $display("FAIL mp_vs_alloc: alloc=%b sq=%b flr=%h required 0000 0011 a",
               allocated_mask, squash_mask, free_list_restore);
    end
    tick();
    idle();
    #1;
    checks++;
    if (current_mask !== 4'b0000) begin
      errors++;
      $display("FAIL mp_vs_alloc_after: cur=%b required 0000", current_mask);
    end
  endtask

  task automatic test_invalid_and_reset();
    do_reset();
    dispatch(64'h1);
    resolve_valid = 1'b1; resolve_mask = 4'b1000; resolve_mispredict = 1'b1;
    #1;
    checks++;
    if (restore_flag !== 1'b0 || squash_mask !== 4'b0000 || free_list_restore !== 64'h0) begin
      errors++;
      $display("FAIL invalid_target: rf=%b sq=%b flr=%h required 0 0000 0",
               restore_flag, squash_mask, free_list_restore);
    end
    tick();
    resolve_mask = 4'b0011;
    #1;
    checks++;
    if (current_mask !== 4'b0001 || restore_flag !== 1'b0 || squash_mask !== 4'b0000) begin
      errors++;
      $display("FAIL non_onehot: cur=%b rf=%b sq=%b required 0001 0 0000",
               current_mask, restore_flag, squash_mask);
    end
    tick();
    idle();
    #1;
    checks++;
    if (current_mask !== 4'b0001) begin
      errors++;
      $display("FAIL invalid_unchanged: cur=%b required 0001", current_mask);
    end
    dispatch(64'h2);
    dispatch(64'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (current_mask !== 4'b0000 || stack_full !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: cur=%b full=%b required 0000 0", current_mask, stack_full);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #2;
    test_reset();
    test_fill();
    test_retire();
    test_squash();
    test_correct_resolve();
    test_mispredict_vs_alloc();
    test_invalid_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
